inst_loader: RTL and testbench
==============================

// Module: inst_loader
// PURPOSE
//  Boot-time program loader, directly upstream of the instruction RAM write port.
//  Takes a byte stream from the UART receiver and packs little-endian bytes into 32-bit words.
//  Writes each word to consecutive instruction-RAM addresses (we/waddr/di).
//  Frame: 4-byte word count, then the payload words, then a 1-byte XOR checksum; reports done/err.
// PARAMETERS
//  ADDR_W     10    instruction RAM address width
//  DEPTH      1024  instruction RAM depth in words
//  BASE_ADDR  0     first word address written; usable space = DEPTH-BASE_ADDR
// PORTS
//  clk       in   1       system clock, all state on posedge
//  rstn      in   1       asynchronous active-low reset
//  start     in   1       1-cycle pulse: arm and begin a new frame
//  rx_valid  in   1       rx_data valid this cycle (1-cycle strobe per byte)
//  rx_data   in   8       received byte
//  we        out  1       instruction RAM write enable (1-cycle pulse per word)
//  waddr     out  ADDR_W  instruction RAM write address
//  di        out  32      instruction RAM write data
//  busy      out  1       frame in progress (states LEN, DATA, CSUM)
//  done      out  1       frame accepted, checksum good; held until next start
//  err       out  1       frame rejected; held until next start
// BEHAVIOUR
//  Reset: state=IDLE; we=0, waddr=0, di=0, busy=0, done=0, err=0; counters, len, csum cleared.
//  States: IDLE, LEN, DATA, CSUM, DONE, ERR. All outputs are registered.
//  start in any state: clear byte_cnt, word_idx, len, csum; clear done/err; go to LEN.
//   start wins over a same-cycle rx_valid; that byte is dropped.
//  IDLE/DONE/ERR: rx_valid ignored.
//  LEN: shift in 4 bytes LSB-first into len[31:0]. On the 4th byte:
//   - len > DEPTH-BASE_ADDR: go to ERR.
//   - len == 0: go to CSUM.
//   - otherwise: go to DATA.
//  DATA: byte_cnt (2b) counts bytes within a word; bytes are little-endian (byte0 -> di[7:0]).
//   Every data byte is XORed into csum[7:0]. Length bytes are excluded from csum.
//   On the 4th byte of a word: the next cycle drives we=1, waddr=BASE_ADDR+word_idx, di=word.
//    word_idx then increments. Latency from 4th rx_valid to we is 1 cycle.
//   When word (len-1) is written: go to CSUM. byte_cnt wraps 3->0.
//  CSUM: next rx byte is compared with csum.
//   - equal: go to DONE, done=1.
//   - unequal: go to ERR, err=1.
//   Words already written are not rolled back.
//  we is 0 in every cycle except the write cycle. waddr/di hold their last values while we=0.
//  rx_valid on consecutive cycles must be accepted without loss (one byte per clk).
//  Reset mid-frame aborts immediately: any pending write is dropped and we=0.
//  waddr never exceeds DEPTH-1, guaranteed by the LEN bound check.
// TESTING
//  1 Reset asserted mid-stream -> all outputs 0, state IDLE; bytes without start produce no we.
//  2 start; bytes 02 00 00 00, 44 33 22 11, EF BE AD DE, 66
//     -> we@addr0 di=32'h11223344, we@addr1 di=32'hDEADBEEF, then done=1, err=0, busy=0.
//  3 Same frame with checksum 67 -> both words written, err=1, done=0.
//  4 start; bytes 01 04 00 00 (len=1025, BASE_ADDR=0) -> err=1 after 4th byte; no we ever.
//  5 start; bytes 00 00 00 00, 00 -> no we, done=1.
//     Repeat with random 0-5 cycle gaps between rx_valid: identical results.
//  6 start; len=2; send 6 data bytes; start again; send the test-2 frame
//     -> only test-2 writes after the restart, addr0 first, done=1.
//     start coincident with rx_valid: that byte is dropped.

Source files
------------

// File: rtl/inst_loader.sv
// Boot-time program loader: packs a UART byte stream (length, payload, XOR checksum)
// into 32-bit little-endian words and writes them to consecutive instruction-RAM addresses.
module inst_loader #(
   parameter int ADDR_W    = 10,
   parameter int DEPTH     = 1024,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              we,
   output logic [ADDR_W-1:0] waddr,
   output logic [31:0]       di,
   output logic              busy,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LEN  = 3'd1,
      S_DATA = 3'd2,
      S_CSUM = 3'd3,
      S_DONE = 3'd4,
      S_ERR  = 3'd5
   } state_t;

   localparam logic [31:0] MAX_LEN = 32'(DEPTH - BASE_ADDR);

   // Running XOR checksum over payload bytes.
   function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
      csum_upd = c ^ b;
   endfunction

   state_t            state_r;
   logic [1:0]        byte_cnt_r;
   logic [ADDR_W:0]   word_idx_r;
   logic [31:0]       len_r;
   logic [31:0]       word_r;
   logic [7:0]        csum_r;
   logic              we_r;
   logic [ADDR_W-1:0] waddr_r;
   logic [31:0]       di_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;

   logic [31:0]       len_next_s;
   logic [31:0]       word_next_s;
   logic [7:0]        csum_next_s;
   logic              last_word_s;

   // Shifted length/word, updated checksum and last-word detection for the current byte.
   always_comb begin
      len_next_s  = {rx_data, len_r[31:8]};
      word_next_s = {rx_data, word_r[31:8]};
      csum_next_s = csum_upd(csum_r, rx_data);
      last_word_s = (32'(word_idx_r) == (len_r - 32'd1));
   end

   // Frame FSM with registered RAM write port and status outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r    <= S_IDLE;
         byte_cnt_r <= 2'd0;
         word_idx_r <= '0;
         len_r      <= 32'd0;
         word_r     <= 32'd0;
         csum_r     <= 8'd0;
         we_r       <= 1'b0;
         waddr_r    <= '0;
         di_r       <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         we_r <= 1'b0;
         if (start) begin
            // A byte arriving in the same cycle as start is deliberately dropped.
            state_r    <= S_LEN;
            byte_cnt_r <= 2'd0;
            word_idx_r <= '0;
            len_r      <= 32'd0;
            word_r     <= 32'd0;
            csum_r     <= 8'd0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
         end else begin
            case (state_r)
               S_LEN: begin
                  if (rx_valid) begin
                     len_r      <= len_next_s;
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                     if (byte_cnt_r == 2'd3) begin
                        if (len_next_s > MAX_LEN) begin
                           state_r <= S_ERR;
                           err_r   <= 1'b1;
                           busy_r  <= 1'b0;
                        end else if (len_next_s == 32'd0) begin
                           state_r <= S_CSUM;
                        end else begin
                           state_r <= S_DATA;
                        end
                     end
                  end
               end
               S_DATA: begin
                  if (rx_valid) begin
                     word_r     <= word_next_s;
                     csum_r     <= csum_next_s;
                     byte_cnt_r <= byte_cnt_r + 2'd1;
                     if (byte_cnt_r == 2'd3) begin
                        we_r       <= 1'b1;
                        waddr_r    <= ADDR_W'(BASE_ADDR) + word_idx_r[ADDR_W-1:0];
                        di_r       <= word_next_s;
                        word_idx_r <= word_idx_r + 1'b1;
                        if (last_word_s) begin
                           state_r <= S_CSUM;
                        end
                     end
                  end
               end
               S_CSUM: begin
                  if (rx_valid) begin
                     busy_r <= 1'b0;
                     if (rx_data == csum_r) begin
                        state_r <= S_DONE;
                        done_r  <= 1'b1;
                     end else begin
                        state_r <= S_ERR;
                        err_r   <= 1'b1;
                     end
                  end
               end
               S_IDLE, S_DONE, S_ERR: begin
                  state_r <= state_r;
               end
               default: begin
                  state_r <= S_IDLE;
                  busy_r  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign we    = we_r;
   assign waddr = waddr_r;
   assign di    = di_r;
   assign busy  = busy_r;
   assign done  = done_r;
   assign err   = err_r;

   inst_loader_chk u_chk (
      .clk  (clk),
      .rstn (rstn),
      .we   (we_r),
      .busy (busy_r),
      .done (done_r),
      .err  (err_r)
   );

endmodule

// Protocol invariants of the loader outputs.
module inst_loader_chk (
   input logic clk,
   input logic rstn,
   input logic we,
   input logic busy,
   input logic done,
   input logic err
);

   a_done_err_excl : assert property (@(posedge clk) disable iff (!rstn) !(done && err));
   a_we_in_frame   : assert property (@(posedge clk) disable iff (!rstn) we |-> busy);
   a_status_idle   : assert property (@(posedge clk) disable iff (!rstn) (done || err) |-> !busy);

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: frames, checksum errors, length bound, restart and reset abort.
module tb_inst_loader;

   logic        clk = 1'b0;
   logic        rstn;
   logic        start;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        we;
   logic [9:0]  waddr;
   logic [31:0] di;
   logic        busy;
   logic        done;
   logic        err;

   int total = 0;
   int bad   = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   inst_loader #(.ADDR_W(10), .DEPTH(1024), .BASE_ADDR(0)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .we       (we),
      .waddr    (waddr),
      .di       (di),
      .busy     (busy),
      .done     (done),
      .err      (err)
   );

   always #5 clk = ~clk;

   // Record every RAM write seen away from the clock edge.
   always @(negedge clk) begin
      if (rstn && we) begin
         wa_q.push_back(32'(waddr));
         wd_q.push_back(di);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1; leaves the bench at posedge+1 after the byte and its gap.
   task automatic send(input logic [7:0] b, input int gap);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic clear_q();
      wa_q.delete();
      wd_q.delete();
   endtask

   // The two-word frame; optional random gaps and a write-latency probe after byte 8.
   task automatic send_t2(input logic [7:0] cs, input int maxgap, input bit lat);
      logic [7:0] fr [13];
      fr = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
             8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
      fr[12] = cs;
      for (int i = 0; i < 13; i++) begin
         rx_data  = fr[i];
         rx_valid = 1'b1;
         @(posedge clk); #1;
         rx_valid = 1'b0;
         if (lat && i == 7) begin
            check_val("lat_we", 32'(we), 32'd1);
            check_val("lat_waddr", 32'(waddr), 32'd0);
            check_val("lat_di", di, 32'h11223344);
         end
         if (maxgap > 0) begin
            repeat ($urandom_range(0, maxgap)) begin @(posedge clk); #1; end
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic check_t2_writes(input string tag);
      check_val({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         check_val({tag, "_a0"}, wa_q[0], 32'd0);
         check_val({tag, "_d0"}, wd_q[0], 32'h11223344);
         check_val({tag, "_a1"}, wa_q[1], 32'd1);
         check_val({tag, "_d1"}, wd_q[1], 32'hDEADBEEF);
      end
   endtask

   initial begin
      logic [7:0] pre [8];
      pre = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      rstn = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(posedge clk); #1;
      check_val("rst_we", 32'(we), 32'd0);
      check_val("rst_waddr", 32'(waddr), 32'd0);
      check_val("rst_di", di, 32'd0);
      check_val("rst_stat", {29'd0, busy, done, err}, 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;

      // 1: reset mid-stream drops the pending write; bytes without start do nothing
      clear_q();
      pulse_start();
      check_val("t1_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 8; i++) send(pre[i], 0);
      rstn = 1'b0;
      #1;
      check_val("t1_we_abort", 32'(we), 32'd0);
      check_val("t1_di_abort", di, 32'd0);
      check_val("t1_stat_abort", {29'd0, busy, done, err}, 32'd0);
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) send(pre[i], 0);
      repeat (2) @(posedge clk); #1;
      check_val("t1_nwr", 32'(wa_q.size()), 32'd0);
      check_val("t1_idle", {29'd0, busy, done, err}, 32'd0);

      // 2: good two-word frame, back-to-back bytes
      clear_q();
      pulse_start();
      send_t2(8'h66, 0, 1'b1);
      check_t2_writes("t2");
      check_val("t2_stat", {29'd0, busy, done, err}, 32'b010);

      // 3: bad checksum, words still written
      clear_q();
      pulse_start();
      send_t2(8'h67, 0, 1'b0);
      check_t2_writes("t3");
      check_val("t3_stat", {29'd0, busy, done, err}, 32'b001);

      // 4: len=1025 exceeds space
      clear_q();
      pulse_start();
      send(8'h01, 0); send(8'h04, 0); send(8'h00, 0);
      check_val("t4_busy_len", {29'd0, busy, done, err}, 32'b100);
      send(8'h00, 0);
      check_val("t4_stat", {29'd0, busy, done, err}, 32'b001);
      for (int i = 0; i < 8; i++) send(pre[i + 0] ^ 8'h5A, 0);
      check_val("t4_nwr", 32'(wa_q.size()), 32'd0);
      check_val("t4_held", {29'd0, busy, done, err}, 32'b001);

      // len=1024 is exactly the usable space and is accepted
      pulse_start();
      send(8'h00, 0); send(8'h04, 0); send(8'h00, 0); send(8'h00, 0);
      check_val("t4_len_max", {29'd0, busy, done, err}, 32'b100);

      // 5: empty frame, then with random gaps; also the full frame with gaps
      clear_q();
      pulse_start();
      for (int i = 0; i < 5; i++) send(8'h00, 0);
      check_val("t5_nwr", 32'(wa_q.size()), 32'd0);
      check_val("t5_stat", {29'd0, busy, done, err}, 32'b010);
      pulse_start();
      check_val("t5_restart", {29'd0, busy, done, err}, 32'b100);
      for (int i = 0; i < 5; i++) send(8'h00, $urandom_range(0, 5));
      check_val("t5g_nwr", 32'(wa_q.size()), 32'd0);
      check_val("t5g_stat", {29'd0, busy, done, err}, 32'b010);
      pulse_start();
      send_t2(8'h66, 5, 1'b0);
      check_t2_writes("t5f");
      check_val("t5f_stat", {29'd0, busy, done, err}, 32'b010);

      // 6: abandoned frame, restart with a coincident byte that must be dropped
      clear_q();
      pulse_start();
      send(8'h02, 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
      for (int i = 0; i < 6; i++) send(8'hA0 + 8'(i), 0);
      check_val("t6_partial", 32'(wa_q.size()), 32'd1);
      clear_q();
      start    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'h05;
      @(posedge clk); #1;
      start    = 1'b0;
      rx_valid = 1'b0;
      send_t2(8'h66, 0, 1'b0);
      check_t2_writes("t6");
      check_val("t6_stat", {29'd0, busy, done, err}, 32'b010);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
